// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared pipeline constants for fetch, NPC calculator and IM
package fetch_stage_pkg;

  // Address widths shared with the next-PC calculator and instruction memory
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned IM_WORDS    = 4096;
  localparam int unsigned IM_WORD_AW  = 12;            // word index into IM
  localparam int unsigned IM_BYTE_AW  = IM_WORD_AW + 2; // byte offset into IM

  // Fetch PC after reset; also the base of the instruction-memory window
  localparam logic [ADDR_W-1:0] PC_RESET = 32'h0000_3000;

  // Last legal word address of the instruction-memory window
  localparam logic [ADDR_W-1:0] PC_LAST =
    PC_RESET + (ADDR_W'(IM_WORDS) << 2) - 32'd4;

  // Bubble encoding (sll $0,$0,0)
  localparam logic [31:0] NOP = 32'h0000_0000;

  // Link distance past a jal/jalr: skips the delay slot
  localparam logic [ADDR_W-1:0] LINK_OFFSET = 32'd8;

  // Unsigned window check on the full 32-bit fetch address
  function automatic logic pc_in_range(input logic [ADDR_W-1:0] pc);
    return (pc >= PC_RESET) && (pc <= PC_LAST);
  endfunction

  // Address error on fetch: misaligned word or outside the IM window
  function automatic logic pc_adel(input logic [ADDR_W-1:0] pc);
    return (pc[1:0] != 2'b00) || !pc_in_range(pc);
  endfunction

endpackage

// File: rtl/fd_pipe_reg.sv
// rtl/fd_pipe_reg.sv - IF/ID pipeline register with reset/flush/stall priority
module fd_pipe_reg
  import fetch_stage_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic [31:0]       instr_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              adel_i,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              valid_o,
  output logic              adel_o
);

  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc_q,    pc_d;
  logic              valid_q, valid_d;
  logic              adel_q,  adel_d;

  // Next-state: flush beats stall so a stalled D slot can still be squashed
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    adel_d  = adel_q;
    if (flush_i) begin
      instr_d = NOP;
      pc_d    = pc_i;
      valid_d = 1'b0;
      adel_d  = 1'b0;
    end else if (!stall_i) begin
      // A faulting fetch must not hand garbage to decode; it travels as a nop
      instr_d = adel_i ? NOP : instr_i;
      pc_d    = pc_i;
      valid_d = 1'b1;
      adel_d  = adel_i;
    end
  end

  // State register; reset loads a bubble sitting at the reset PC
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      instr_q <= NOP;
      pc_q    <= PC_RESET;
      valid_q <= 1'b0;
      adel_q  <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      adel_q  <= adel_d;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;
  assign adel_o  = adel_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS fetch stage: program counter, range check, IF/ID register
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              npcValid,
  input  logic [ADDR_W-1:0] NPC,
  input  logic [31:0]       imInstr,
  output logic [ADDR_W-1:0] F_PC,
  output logic              F_AdEL,
  output logic [31:0]       D_Instr,
  output logic [ADDR_W-1:0] D_PC,
  output logic [ADDR_W-1:0] D_PC8,
  output logic              D_Valid,
  output logic              D_AdEL
);

  logic [ADDR_W-1:0] pc_q, pc_d;

  // Next PC: stall holds (the branch re-asserts npcValid later), redirect
  // loads the target even if it is bad so the fault is reported, else PC+4
  always_comb begin
    pc_d = pc_q;
    if (!stall) begin
      if (npcValid) begin
        pc_d = NPC;
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end
  end

  // Program counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign F_PC   = pc_q;
  assign F_AdEL = pc_adel(pc_q);

  // The delay slot at F_PC is latched normally on a redirect; only flush squashes
  fd_pipe_reg u_fd_pipe_reg (
    .clk_i   (clk),
    .reset_i (reset),
    .flush_i (flush),
    .stall_i (stall),
    .instr_i (imInstr),
    .pc_i    (pc_q),
    .adel_i  (F_AdEL),
    .instr_o (D_Instr),
    .pc_o    (D_PC),
    .valid_o (D_Valid),
    .adel_o  (D_AdEL)
  );

  assign D_PC8 = D_PC + LINK_OFFSET;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        npcValid;
  logic [31:0] NPC;
  logic [31:0] imInstr;
  logic [31:0] F_PC;
  logic        F_AdEL;
  logic [31:0] D_Instr;
  logic [31:0] D_PC;
  logic [31:0] D_PC8;
  logic        D_Valid;
  logic        D_AdEL;

  int n_cmp = 0;
  int n_err = 0;

  fetch_stage dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .flush    (flush),
    .npcValid (npcValid),
    .NPC      (NPC),
    .imInstr  (imInstr),
    .F_PC     (F_PC),
    .F_AdEL   (F_AdEL),
    .D_Instr  (D_Instr),
    .D_PC     (D_PC),
    .D_PC8    (D_PC8),
    .D_Valid  (D_Valid),
    .D_AdEL   (D_AdEL)
  );

  always #5 clk = ~clk;

  // Instruction memory stand-in: each word tagged with its own address
  assign imInstr = {16'hC0DE, F_PC[15:0]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".F_PC"},    F_PC,    32'h0000_3000);
    check({tag, ".F_AdEL"},  F_AdEL,  32'd0);
    check({tag, ".D_PC"},    D_PC,    32'h0000_3000);
    check({tag, ".D_PC8"},   D_PC8,   32'h0000_3008);
    check({tag, ".D_Instr"}, D_Instr, 32'd0);
    check({tag, ".D_Valid"}, D_Valid, 32'd0);
    check({tag, ".D_AdEL"},  D_AdEL,  32'd0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; npcValid = 1'b0; NPC = 32'd0;
    #2;
    check_reset_state("rst0");
    do_reset();
    check_reset_state("rst1");

    // Free run: 3000 -> 3004 -> 3008 -> 300C, D lags one cycle
    tick();
    check("run1.F_PC", F_PC, 32'h3004);
    check("run1.D_PC", D_PC, 32'h3000);
    check("run1.D_PC8", D_PC8, 32'h3008);
    check("run1.D_Valid", D_Valid, 32'd1);
    check("run1.D_Instr", D_Instr, 32'hC0DE3000);
    tick();
    check("run2.F_PC", F_PC, 32'h3008);
    check("run2.D_PC", D_PC, 32'h3004);
    tick();
    check("run3.F_PC", F_PC, 32'h300C);
    check("run3.D_PC", D_PC, 32'h3008);
    check("run3.D_PC8", D_PC8, 32'h3010);
    tick();
    check("run4.F_PC", F_PC, 32'h3010);

    // Redirect at 3010 to 3100: delay slot 3010 reaches D, then the target
    npcValid = 1'b1; NPC = 32'h3100;
    tick();
    npcValid = 1'b0;
    check("br1.F_PC", F_PC, 32'h3100);
    check("br1.D_PC", D_PC, 32'h3010);
    check("br1.D_Instr", D_Instr, 32'hC0DE3010);
    check("br1.D_Valid", D_Valid, 32'd1);
    tick();
    check("br2.F_PC", F_PC, 32'h3104);
    check("br2.D_PC", D_PC, 32'h3100);

    // Stall two cycles at 3008 with a pending redirect to 3200
    do_reset();
    tick(); tick();
    check("st0.F_PC", F_PC, 32'h3008);
    stall = 1'b1; npcValid = 1'b1; NPC = 32'h3200;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("st%0d.F_PC", i + 1), F_PC, 32'h3008);
      check($sformatf("st%0d.D_PC", i + 1), D_PC, 32'h3004);
      check($sformatf("st%0d.D_Instr", i + 1), D_Instr, 32'hC0DE3004);
      check($sformatf("st%0d.D_Valid", i + 1), D_Valid, 32'd1);
    end
    stall = 1'b0;
    tick();
    npcValid = 1'b0;
    check("st3.F_PC", F_PC, 32'h3200);
    check("st3.D_PC", D_PC, 32'h3008);

    // Flush and stall together with 3004 in D
    do_reset();
    tick(); tick();
    check("fl0.D_PC", D_PC, 32'h3004);
    stall = 1'b1; flush = 1'b1;
    tick();
    stall = 1'b0; flush = 1'b0;
    check("fl1.D_Valid", D_Valid, 32'd0);
    check("fl1.D_Instr", D_Instr, 32'd0);
    check("fl1.D_PC", D_PC, 32'h3008);
    check("fl1.F_PC", F_PC, 32'h3008);

    // Bad redirect targets: misaligned, below window, one past window
    do_reset();
    npcValid = 1'b1; NPC = 32'h3102;
    tick();
    check("ad1.F_PC", F_PC, 32'h3102);
    check("ad1.F_AdEL", F_AdEL, 32'd1);
    NPC = 32'h0000_2FFC;
    tick();
    check("ad2.F_AdEL", F_AdEL, 32'd1);
    check("ad2.D_PC", D_PC, 32'h3102);
    check("ad2.D_Instr", D_Instr, 32'd0);
    check("ad2.D_AdEL", D_AdEL, 32'd1);
    check("ad2.D_Valid", D_Valid, 32'd1);
    NPC = 32'h0000_7000;
    tick();
    check("ad3.F_AdEL", F_AdEL, 32'd1);
    check("ad3.D_PC", D_PC, 32'h2FFC);
    check("ad3.D_AdEL", D_AdEL, 32'd1);
    NPC = 32'h0000_6FFC;
    tick();
    check("ad4.F_AdEL", F_AdEL, 32'd0);
    check("ad4.D_PC", D_PC, 32'h7000);
    check("ad4.D_Instr", D_Instr, 32'd0);
    check("ad4.D_AdEL", D_AdEL, 32'd1);
    npcValid = 1'b0;
    tick();
    check("ad5.F_PC", F_PC, 32'h7000);
    check("ad5.D_PC", D_PC, 32'h6FFC);
    check("ad5.D_Instr", D_Instr, 32'hC0DE6FFC);
    check("ad5.D_AdEL", D_AdEL, 32'd0);

    // Asynchronous reset mid-cycle with F_PC=3040
    npcValid = 1'b1; NPC = 32'h3040;
    tick();
    npcValid = 1'b0;
    check("ar0.F_PC", F_PC, 32'h3040);
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("ar1");
    reset = 1'b0;
    tick();
    check("ar2.F_PC", F_PC, 32'h3004);
    check("ar2.D_PC", D_PC, 32'h3000);

    // Reset released while stalled: first edge holds
    stall = 1'b1;
    do_reset();
    tick();
    check_reset_state("rs1");
    stall = 1'b0;
    tick();
    check("rs2.F_PC", F_PC, 32'h3004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
